// File: rtl/uart_rx.sv
// 8N1 UART receiver with OVERSAMPLE x clock, FIFO put/full write port and rts throttle.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around each sample point (decision one clock later).
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       reset,
  input  logic       clock,
  input  logic       rx,
  output logic [7:0] out,
  output logic       put,
  input  logic       full,
  output logic       rts,
  output logic       ferr,
  output logic       ovr
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] tick_reg, tick_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic [7:0]    out_next;
  logic          put_next, ferr_next, ovr_next;
  logic          rx_meta_reg, rx_s;
  logic          sample_pt, sample_val;

  // Synchroniser resets to the idle-high line level so no false start follows reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_s        <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s        <= rx_meta_reg;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  localparam logic [TW-1:0] SAMPLE_TICK = MID + TW'(1);
  logic vote_a_reg, vote_b_reg;

  // Votes at mid-1 and mid are held; the third vote is the live rx_s at mid+1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vote_a_reg <= 1'b1;
      vote_b_reg <= 1'b1;
    end else begin
      if (tick_reg == MID - TW'(1)) vote_a_reg <= rx_s;
      if (tick_reg == MID)          vote_b_reg <= rx_s;
    end
  end

  assign sample_val = (vote_a_reg & vote_b_reg) | (vote_a_reg & rx_s) | (vote_b_reg & rx_s);
`else
  localparam logic [TW-1:0] SAMPLE_TICK = MID;
  assign sample_val = rx_s;
`endif

  assign sample_pt = (tick_reg == SAMPLE_TICK);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      tick_reg    <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      out         <= '0;
      put         <= 1'b0;
      ferr        <= 1'b0;
      ovr         <= 1'b0;
      rts         <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tick_reg    <= tick_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      out         <= out_next;
      put         <= put_next;
      ferr        <= ferr_next;
      ovr         <= ovr_next;
      rts         <= full;
    end
  end

  always_comb begin
    state_next   = state_reg;
    tick_next    = tick_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    out_next     = out;
    put_next     = 1'b0;
    ferr_next    = 1'b0;
    ovr_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        tick_next    = '0;
        bit_cnt_next = '0;
        if (!rx_s) state_next = START;
      end

      START: begin
        tick_next = tick_reg + TW'(1);
        if (sample_pt && sample_val) begin
          state_next = IDLE;
          tick_next  = '0;
        end else if (tick_reg == LAST) begin
          // tick wraps to 0 here, so DATA begins on a bit boundary.
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end

      DATA: begin
        tick_next = tick_reg + TW'(1);
        if (sample_pt) shift_next = {sample_val, shift_reg[7:1]};
        if (tick_reg == LAST) begin
          if (bit_cnt_reg == 3'd7) state_next = STOP;
          else                     bit_cnt_next = bit_cnt_reg + 3'd1;
        end
      end

      STOP: begin
        tick_next = tick_reg + TW'(1);
        if (sample_pt) begin
          tick_next = '0;
          if (sample_val) begin
            // Leave immediately so a start edge in the rest of the stop bit is caught.
            state_next = IDLE;
            if (full) begin
              ovr_next = 1'b1;
            end else begin
              put_next = 1'b1;
              out_next = shift_reg;
            end
          end else begin
            ferr_next  = 1'b1;
            state_next = BREAK;
          end
        end
      end

      BREAK: begin
        tick_next = '0;
        if (rx_s) state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        tick_next  = '0;
      end
    endcase
  end

endmodule
